// File: rtl/mux8_rr_scheduler_if.sv
// Requester-bank <-> scheduler bus: requests and data in, grant, mux control and output back.
interface mux8_rr_scheduler_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] a;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       mux_en;
  logic       y;
  logic       y_valid;

  modport master (
    output en, req, a,
    input  gnt, sel, mux_en, y, y_valid
  );

  modport slave (
    input  en, req, a,
    output gnt, sel, mux_en, y, y_valid
  );
endinterface

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 single-bit mux among 8 requesters, with a bounded
// hold time per grant and a registered mux output plus valid strobe.
module mux8_rr_scheduler #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mux8_rr_scheduler_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q;
  logic [2:0]       ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       gnt_q;
  logic [2:0]       sel_q;
  logic             mux_en_q;
  logic             y_q;
  logic             y_valid_q;

  logic [2:0] sel_inc;
  logic [7:0] others;
  logic [2:0] idle_win;
  logic [2:0] next_win;
  logic       sel_req;
  logic       at_max;
  logic       grant_live;

  // First set bit scanning start, start+1, ... with 3-bit wrap; lowest offset wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    rr_pick = start;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    sel_inc    = sel_q + 3'd1;
    others     = bus.req & ~(8'b1 << sel_q);
    idle_win   = rr_pick(bus.req, ptr_q);
    next_win   = rr_pick(others, sel_inc);
    sel_req    = bus.req[sel_q];
    at_max     = (cnt_q == CNT_W'(MAX_HOLD));
    grant_live = (state_q == StGrant) && bus.en && sel_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd0;
      cnt_q     <= '0;
      gnt_q     <= 8'd0;
      sel_q     <= 3'd0;
      mux_en_q  <= 1'b0;
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= grant_live;
      if (grant_live) y_q <= bus.a[sel_q];

      unique case (state_q)
        StIdle: begin
          if (bus.en && (|bus.req)) begin
            state_q  <= StGrant;
            gnt_q    <= 8'b1 << idle_win;
            sel_q    <= idle_win;
            mux_en_q <= 1'b1;
            cnt_q    <= CNT_W'(1);
          end
        end
        StGrant: begin
          if (!bus.en) begin
            // Pointer deliberately left alone so re-enable resumes the same rotation.
            state_q  <= StIdle;
            gnt_q    <= 8'd0;
            mux_en_q <= 1'b0;
          end else if (!sel_req) begin
            ptr_q <= sel_inc;
            if (|others) begin
              gnt_q <= 8'b1 << next_win;
              sel_q <= next_win;
              cnt_q <= CNT_W'(1);
            end else begin
              state_q  <= StIdle;
              gnt_q    <= 8'd0;
              mux_en_q <= 1'b0;
            end
          end else if (at_max && (|others)) begin
            ptr_q <= sel_inc;
            gnt_q <= 8'b1 << next_win;
            sel_q <= next_win;
            cnt_q <= CNT_W'(1);
          end else if (!at_max) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.mux_en  = mux_en_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed bench for mux8_rr_scheduler: reset, hold, rotation, release wrap, enable and preemption.
module tb_mux8_rr_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux8_rr_scheduler_if bus ();

  mux8_rr_scheduler #(
    .MAX_HOLD (4),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    bus.a   = 8'h00;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.en  = 1'b1;
    bus.req = 8'h04;
    bus.a   = 8'hFF;
    step();
    step();
    checks++;
    if (bus.y_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_yvalid got %0b want 1", bus.y_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== 8'h00 || bus.mux_en !== 1'b0 || bus.y_valid !== 1'b0 ||
        bus.sel !== 3'd0 || bus.y !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got gnt=%h mux_en=%0b y_valid=%0b sel=%0d y=%0b want all 0",
               bus.gnt, bus.mux_en, bus.y_valid, bus.sel, bus.y);
    end
    bus.req = 8'h00;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.gnt !== 8'h00 || bus.mux_en !== 1'b0 || bus.y_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle got gnt=%h mux_en=%0b y_valid=%0b want 0",
                 bus.gnt, bus.mux_en, bus.y_valid);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.a   = 8'b1010_1010;
    bus.req = 8'b0000_0010;
    bus.en  = 1'b1;
    step();
    checks++;
    if (bus.gnt !== 8'h02 || bus.sel !== 3'd1 || bus.mux_en !== 1'b1 || bus.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got gnt=%h sel=%0d mux_en=%0b y_valid=%0b want 02 1 1 0",
               bus.gnt, bus.sel, bus.mux_en, bus.y_valid);
    end
    step();
    checks++;
    if (bus.y_valid !== 1'b1 || bus.y !== 1'b1) begin
      errors++;
      $display("FAIL single_data got y_valid=%0b y=%0b want 1 1", bus.y_valid, bus.y);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.gnt !== 8'h02 || bus.sel !== 3'd1) begin
        errors++;
        $display("FAIL single_hold cycle %0d got gnt=%h sel=%0d want 02 1", i, bus.gnt, bus.sel);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_sel;
    logic [2:0] prev_sel;
    bit         first;
    do_reset();
    bus.a   = 8'b1010_1010;
    bus.req = 8'hFF;
    bus.en  = 1'b1;
    first   = 1'b1;
    prev_sel = 3'd0;
    for (int g = 0; g < 9; g++) begin
      exp_sel = 3'(g % 8);
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (bus.sel !== exp_sel || bus.gnt !== (8'h01 << exp_sel)) begin
          errors++;
          $display("FAIL rr_sel grant %0d cyc %0d got sel=%0d gnt=%h want sel=%0d",
                   g, c, bus.sel, bus.gnt, exp_sel);
        end
        if (!first) begin
          // a = 0xAA, so a[i] is 1 exactly for odd i; y lags sel by one cycle
          checks++;
          if (bus.y_valid !== 1'b1 || bus.y !== prev_sel[0]) begin
            errors++;
            $display("FAIL rr_y grant %0d cyc %0d got y_valid=%0b y=%0b want 1 %0b",
                     g, c, bus.y_valid, bus.y, prev_sel[0]);
          end
        end
        first    = 1'b0;
        prev_sel = exp_sel;
      end
    end
  endtask

  task automatic test_release_wrap();
    do_reset();
    bus.a   = 8'h00;
    bus.req = 8'h80;
    bus.en  = 1'b1;
    step();
    checks++;
    if (bus.sel !== 3'd7 || bus.gnt !== 8'h80) begin
      errors++;
      $display("FAIL wrap_start got sel=%0d gnt=%h want 7 80", bus.sel, bus.gnt);
    end
    bus.req = 8'h81;
    step();
    bus.req = 8'h01;
    step();
    checks++;
    if (bus.gnt !== 8'h01 || bus.sel !== 3'd0 || bus.mux_en !== 1'b1) begin
      errors++;
      $display("FAIL wrap_release got gnt=%h sel=%0d mux_en=%0b want 01 0 1",
               bus.gnt, bus.sel, bus.mux_en);
    end
    bus.req = 8'h00;
    step();
    checks++;
    if (bus.gnt !== 8'h00 || bus.mux_en !== 1'b0) begin
      errors++;
      $display("FAIL wrap_idle got gnt=%h mux_en=%0b want 00 0", bus.gnt, bus.mux_en);
    end
    // ptr is now 1: with req[0] and req[1] both set, requester 1 must win
    bus.req = 8'h03;
    step();
    checks++;
    if (bus.gnt !== 8'h02 || bus.sel !== 3'd1) begin
      errors++;
      $display("FAIL wrap_ptr got gnt=%h sel=%0d want 02 1", bus.gnt, bus.sel);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    bus.a   = 8'h08;
    bus.req = 8'h08;
    bus.en  = 1'b1;
    step();
    step();
    checks++;
    if (bus.sel !== 3'd3 || bus.y_valid !== 1'b1 || bus.y !== 1'b1) begin
      errors++;
      $display("FAIL en_setup got sel=%0d y_valid=%0b y=%0b want 3 1 1",
               bus.sel, bus.y_valid, bus.y);
    end
    bus.en  = 1'b0;
    bus.a   = 8'h00;
    bus.req = 8'h18;
    step();
    checks++;
    if (bus.gnt !== 8'h00 || bus.mux_en !== 1'b0 || bus.sel !== 3'd3 ||
        bus.y_valid !== 1'b0 || bus.y !== 1'b1) begin
      errors++;
      $display("FAIL en_drop got gnt=%h mux_en=%0b sel=%0d y_valid=%0b y=%0b want 00 0 3 0 1",
               bus.gnt, bus.mux_en, bus.sel, bus.y_valid, bus.y);
    end
    step();
    checks++;
    if (bus.y_valid !== 1'b0 || bus.y !== 1'b1 || bus.gnt !== 8'h00) begin
      errors++;
      $display("FAIL en_off got y_valid=%0b y=%0b gnt=%h want 0 1 00",
               bus.y_valid, bus.y, bus.gnt);
    end
    bus.en = 1'b1;
    step();
    checks++;
    if (bus.gnt !== 8'h08 || bus.sel !== 3'd3 || bus.mux_en !== 1'b1) begin
      errors++;
      $display("FAIL en_resume got gnt=%h sel=%0d mux_en=%0b want 08 3 1",
               bus.gnt, bus.sel, bus.mux_en);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.a   = 8'h40;
    bus.req = 8'h20;
    bus.en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.gnt !== 8'h20 || bus.sel !== 3'd5) begin
        errors++;
        $display("FAIL sim_hold cyc %0d got gnt=%h sel=%0d want 20 5", i, bus.gnt, bus.sel);
      end
    end
    bus.req = 8'h60;
    step();
    checks++;
    if (bus.gnt !== 8'h40 || bus.sel !== 3'd6 || bus.mux_en !== 1'b1) begin
      errors++;
      $display("FAIL sim_preempt got gnt=%h sel=%0d mux_en=%0b want 40 6 1",
               bus.gnt, bus.sel, bus.mux_en);
    end
    step();
    checks++;
    if (bus.y_valid !== 1'b1 || bus.y !== 1'b1 || bus.gnt !== 8'h40) begin
      errors++;
      $display("FAIL sim_data got y_valid=%0b y=%0b gnt=%h want 1 1 40",
               bus.y_valid, bus.y, bus.gnt);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    bus.a   = 8'h00;
    #3;
    checks++;
    if (bus.gnt !== 8'h00 || bus.mux_en !== 1'b0 || bus.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL power_on got gnt=%h mux_en=%0b y_valid=%0b want 00 0 0",
               bus.gnt, bus.mux_en, bus.y_valid);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_release_wrap();
    test_enable_drop();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
